// File: rtl/mdm_capture_engine.sv
// mdm_capture_engine: triggered single-channel sample capture into a RAM,
// then drained as a big-endian byte stream towards a UART transmitter.
// Optional macro CAPTURE_HEADER_EN prepends a 4-byte frame header
// (0xA5, ch_sel, frame length MSB, frame length LSB) to every drain.
module mdm_capture_engine #(
   parameter int WIDTH  = 14,
   parameter int NUM_CH = 4,
   parameter int DEPTH  = 2048
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] in_tdata,
   input  logic [NUM_CH-1:0]       in_tvalid,
   input  logic                    cfg_we,
   input  logic [2:0]              cfg_addr,
   input  logic [15:0]             cfg_data,
   input  logic                    fire,
   input  logic                    abort,
   output logic [7:0]              o_tdata,
   output logic                    o_tvalid,
   input  logic                    o_tready,
   output logic                    busy,
   output logic [1:0]              state
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [16:0] DEPTH_L = 17'(DEPTH);
`ifdef CAPTURE_HEADER_EN
   localparam logic [17:0] HDR_BYTES = 18'd4;
`else
   localparam logic [17:0] HDR_BYTES = 18'd0;
`endif

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CAPTURE = 2'd2,
      S_DRAIN   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [3:0]       r_ch_sel;
   logic [1:0]       r_trig_mode;
   logic [WIDTH-1:0] r_threshold;
   logic [15:0]      r_frame_len;
   logic [7:0]       r_decim;

   logic [AW-1:0]    r_wptr;
   logic [7:0]       r_dcnt;
   logic [WIDTH-1:0] r_prev;
   logic             r_prev_vld;
   logic [AW-1:0]    r_raddr;
   logic [17:0]      r_bidx;
   logic             r_tvalid;
   logic [WIDTH-1:0] r_ram_q;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic [3:0]       w_ch_idx;
   logic [WIDTH-1:0] w_cur;
   logic             w_cur_vld;
   logic [16:0]      w_eff_len;
   logic             w_trig;
   logic             w_arm_hit;
   logic             w_keep;
   logic             w_last_wr;
   logic             w_wr_en;
   logic [AW-1:0]    w_wr_addr;
   logic             w_accept;
   logic [17:0]      w_total_m1;
   logic             w_last_byte;
   logic             w_is_lsb;
   logic             w_rd_en;
   logic [15:0]      w_word;
   logic [7:0]       w_byte;

   assign w_eff_len = (r_frame_len == 16'd0 || {1'b0, r_frame_len} > DEPTH_L)
                      ? DEPTH_L : {1'b0, r_frame_len};

   // Map out-of-range channel selects onto the last channel.
   always_comb begin
      w_ch_idx = r_ch_sel;
      if ({1'b0, r_ch_sel} >= 5'(NUM_CH)) w_ch_idx = 4'(NUM_CH - 1);
   end

   // Extract the selected channel's sample and strobe.
   always_comb begin
      w_cur     = '0;
      w_cur_vld = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         if (4'(k) == w_ch_idx) begin
            w_cur     = in_tdata[k*WIDTH +: WIDTH];
            w_cur_vld = in_tvalid[k];
         end
      end
   end

   // Trigger condition; edge modes need a previous sample since arming.
   always_comb begin
      case (r_trig_mode)
         2'd1:    w_trig = r_prev_vld && (r_prev <  r_threshold) && (w_cur >= r_threshold);
         2'd2:    w_trig = r_prev_vld && (r_prev >= r_threshold) && (w_cur <  r_threshold);
         default: w_trig = 1'b1;
      endcase
   end

   assign w_arm_hit = (r_state == S_ARM) && w_cur_vld && w_trig && !abort;
   assign w_keep    = (r_state == S_CAPTURE) && w_cur_vld && (r_dcnt == r_decim) && !abort;
   assign w_last_wr = (17'(r_wptr) == w_eff_len - 17'd1);
   assign w_wr_en   = w_arm_hit || w_keep;
   assign w_wr_addr = w_arm_hit ? '0 : r_wptr;

   assign w_accept    = (r_state == S_DRAIN) && r_tvalid && o_tready && !abort;
   assign w_total_m1  = {w_eff_len, 1'b0} + HDR_BYTES - 18'd1;
   assign w_last_byte = (r_bidx == w_total_m1);
   assign w_word      = 16'(r_ram_q);
   assign w_byte      = r_bidx[0] ? w_word[7:0] : w_word[15:8];

`ifdef CAPTURE_HEADER_EN
   logic [7:0] w_hdr_byte;
   logic       w_in_hdr;
   assign w_in_hdr = (r_bidx < HDR_BYTES);
   // Header bytes ahead of the sample data; sample parity is unchanged as the header is even-sized.
   always_comb begin
      case (r_bidx[1:0])
         2'd0:    w_hdr_byte = 8'hA5;
         2'd1:    w_hdr_byte = {4'b0, r_ch_sel};
         2'd2:    w_hdr_byte = w_eff_len[15:8];
         default: w_hdr_byte = w_eff_len[7:0];
      endcase
   end
   assign w_is_lsb = !w_in_hdr && r_bidx[0];
   assign o_tdata  = !r_tvalid ? 8'h00 : (w_in_hdr ? w_hdr_byte : w_byte);
`else
   assign w_is_lsb = r_bidx[0];
   assign o_tdata  = r_tvalid ? w_byte : 8'h00;
`endif

   // Word 0 is fetched on DRAIN entry; each later word when its predecessor's LSB is taken.
   assign w_rd_en = (r_state == S_DRAIN) && !abort &&
                    (!r_tvalid || (w_accept && w_is_lsb && !w_last_byte));

   assign o_tvalid = r_tvalid;
   assign busy     = (r_state != S_IDLE);
   assign state    = r_state;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state selection; abort overrides every other request.
   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (fire) w_next = S_ARM;
            S_ARM:     if (w_arm_hit) w_next = (w_eff_len == 17'd1) ? S_DRAIN : S_CAPTURE;
            S_CAPTURE: if (w_keep && w_last_wr) w_next = S_DRAIN;
            S_DRAIN:   if (w_accept && w_last_byte) w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   // Config registers, capture pointers and drain sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ch_sel    <= '0;
         r_trig_mode <= '0;
         r_threshold <= '0;
         r_frame_len <= '0;
         r_decim     <= '0;
         r_wptr      <= '0;
         r_dcnt      <= '0;
         r_prev      <= '0;
         r_prev_vld  <= 1'b0;
         r_raddr     <= '0;
         r_bidx      <= '0;
         r_tvalid    <= 1'b0;
      end else if (abort) begin
         r_wptr     <= '0;
         r_dcnt     <= '0;
         r_prev_vld <= 1'b0;
         r_raddr    <= '0;
         r_bidx     <= '0;
         r_tvalid   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cfg_we) begin
                  case (cfg_addr)
                     3'd0:    r_ch_sel    <= cfg_data[3:0];
                     3'd1:    r_trig_mode <= cfg_data[1:0];
                     3'd2:    r_threshold <= cfg_data[WIDTH-1:0];
                     3'd3:    r_frame_len <= cfg_data;
                     3'd4:    r_decim     <= cfg_data[7:0];
                     default: ;
                  endcase
               end
               if (fire) begin
                  r_wptr     <= '0;
                  r_dcnt     <= '0;
                  r_prev_vld <= 1'b0;
                  r_raddr    <= '0;
                  r_bidx     <= '0;
                  r_tvalid   <= 1'b0;
               end
            end
            S_ARM: begin
               if (w_cur_vld) begin
                  r_prev     <= w_cur;
                  r_prev_vld <= 1'b1;
                  if (w_trig) begin
                     r_wptr <= (w_eff_len == 17'd1) ? '0 : AW'(1);
                     r_dcnt <= '0;
                  end
               end
            end
            S_CAPTURE: begin
               if (w_cur_vld) begin
                  if (r_dcnt == r_decim) begin
                     r_dcnt <= '0;
                     if (!w_last_wr) r_wptr <= r_wptr + AW'(1);
                  end else begin
                     r_dcnt <= r_dcnt + 8'd1;
                  end
               end
            end
            default: begin
               if (w_rd_en) r_raddr <= r_raddr + AW'(1);
               if (!r_tvalid) begin
                  r_tvalid <= 1'b1;
                  r_bidx   <= '0;
               end else if (w_accept) begin
                  if (w_last_byte) begin
                     r_tvalid <= 1'b0;
                     r_bidx   <= '0;
                     r_raddr  <= '0;
                  end else begin
                     r_bidx <= r_bidx + 18'd1;
                  end
               end
            end
         endcase
      end
   end

   // Sample buffer: write port for capture, registered read port for drain.
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[w_wr_addr] <= w_cur;
      if (w_rd_en) r_ram_q <= r_mem[r_raddr];
   end

endmodule
